// File: rtl/lc4_regfile_if.sv
// Register-file access bus: two combinational read ports and one write port.
// Clock, reset and the global write enable stay outside as plain module ports.
interface lc4_regfile_if #(
  parameter int n = 16
);
  logic [2:0]   i_rs;
  logic [2:0]   i_rt;
  logic [2:0]   i_rd;
  logic [n-1:0] i_wdata;
  logic         i_rd_we;
  logic [n-1:0] o_rs_data;
  logic [n-1:0] o_rt_data;

  modport master (
    output i_rs, i_rt, i_rd, i_wdata, i_rd_we,
    input  o_rs_data, o_rt_data
  );

  modport slave (
    input  i_rs, i_rt, i_rd, i_wdata, i_rd_we,
    output o_rs_data, o_rt_data
  );
endinterface

// File: rtl/lc4_regfile.sv
// LC4 register file: R0..R7 (R0 is writable), two async read ports, one write port.
// Optional macro LC4_REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module lc4_regfile #(
  parameter int n     = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gwe,
  lc4_regfile_if.slave  bus
);

  logic [n-1:0] r_regs [NREGS];
  logic         w_wr_en;
  logic [n-1:0] w_rs_data;
  logic [n-1:0] w_rt_data;

  // Qualified write strobe; reset and a cleared gwe both block the write.
  always_comb begin
    w_wr_en = (~rst) & gwe & bus.i_rd_we;
  end

  // Storage update; reset wins over any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {n{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[bus.i_rd] <= bus.i_wdata;
    end
  end

  // Read muxes, with optional write-before-read forwarding.
  always_comb begin
    w_rs_data = r_regs[bus.i_rs];
    w_rt_data = r_regs[bus.i_rt];
`ifdef LC4_REGFILE_BYPASS_EN
    if (w_wr_en && (bus.i_rs == bus.i_rd)) begin
      w_rs_data = bus.i_wdata;
    end else begin
      w_rs_data = r_regs[bus.i_rs];
    end
    if (w_wr_en && (bus.i_rt == bus.i_rd)) begin
      w_rt_data = bus.i_wdata;
    end else begin
      w_rt_data = r_regs[bus.i_rt];
    end
`endif
  end

  assign bus.o_rs_data = w_rs_data;
  assign bus.o_rt_data = w_rt_data;

endmodule

// File: tb/tb_lc4_regfile.sv
// Self-checking bench for lc4_regfile: directed vector table, fill/readback, X robustness,
// and randomized traffic against an array-based reference model.
module tb_lc4_regfile;

  localparam int W = 16;
`ifdef LC4_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic gwe;
  int   checks;
  int   errors;
  logic [W-1:0] model [8];

  lc4_regfile_if #(.n(W)) bus ();

  lc4_regfile #(.n(W), .NREGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .gwe (gwe),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic         rst;
    logic         gwe;
    logic         we;
    logic [2:0]   rd;
    logic [W-1:0] wdata;
    logic [2:0]   rs;
    logic [2:0]   rt;
    bit           chk;
    logic [W-1:0] exp_rs;
    logic [W-1:0] exp_rt;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic r, logic g, logic we, logic [2:0] rd, logic [W-1:0] wd,
                              logic [2:0] rs, logic [2:0] rt, bit c,
                              logic [W-1:0] ers, logic [W-1:0] ert);
    vec_t v;
    v.rst = r; v.gwe = g; v.we = we; v.rd = rd; v.wdata = wd;
    v.rs = rs; v.rt = rt; v.chk = c; v.exp_rs = ers; v.exp_rt = ert;
    return v;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Spec-level read: stored value, or same-cycle write data when forwarding is built in.
  function automatic logic [W-1:0] model_read(logic [2:0] spec, logic r, logic g, logic we,
                                              logic [2:0] rd, logic [W-1:0] wd);
    if (BYP && r === 1'b0 && g === 1'b1 && we === 1'b1 && spec === rd) return wd;
    return model[spec];
  endfunction

  // Drive one cycle: inputs settle, optional pre-edge compare, edge, model update.
  task automatic apply(string name, logic r, logic g, logic we, logic [2:0] rd,
                       logic [W-1:0] wd, logic [2:0] rs, logic [2:0] rt, bit c,
                       logic [W-1:0] ers, logic [W-1:0] ert);
    rst = r; gwe = g;
    bus.i_rd_we = we; bus.i_rd = rd; bus.i_wdata = wd;
    bus.i_rs = rs; bus.i_rt = rt;
    #1;
    if (c) begin
      check({name, "_rs"}, bus.o_rs_data, ers);
      check({name, "_rt"}, bus.o_rt_data, ert);
    end
    @(posedge clk);
    if (r === 1'b1) begin
      for (int k = 0; k < 8; k++) model[k] = '0;
    end else if (g === 1'b1 && we === 1'b1) begin
      model[rd] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 8; k++) model[k] = '0;
    rst = 1'b1; gwe = 1'b0;
    bus.i_rd_we = 1'b0; bus.i_rd = 3'd0; bus.i_wdata = '0;
    bus.i_rs = 3'd0; bus.i_rt = 3'd0;
    @(negedge clk);

    vecs[0] = mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 8; k++)
      vecs[1+k] = mk(1'b0, 1'b1, 1'b0, 3'd0, 16'hFFFF, 3'(k), 3'(7-k), 1'b1, 16'h0000, 16'h0000);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1, 1'b1, 16'h0000, 16'h0000);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b1, 16'hBEEF, 16'hBEEF);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b1, 16'h0000, 16'h0000);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 3'd5, 16'h1234, 3'd5, 3'd2, 1'b1, 16'h0000, 16'h0000);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd4, 1'b1, 16'h0000, 16'h0000);
    vecs[14] = mk(1'b0, 1'b1, 1'b1, 3'd6, 16'hAAAA, 3'd7, 3'd3, 1'b1, 16'h0000, 16'hBEEF);
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 3'd6, 16'h5555, 3'd6, 3'd6, 1'b1, 16'hAAAA, 16'hAAAA);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd3, 1'b1, 16'h0000, 16'h0000);
    vecs[17] = mk(1'b0, 1'b1, 1'b1, 3'd2, 16'h0001, 3'd0, 3'd1, 1'b1, 16'h0000, 16'h0000);
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 3'd2, 16'h00F0, 3'd2, 3'd3, 1'b1,
                  BYP ? 16'h00F0 : 16'h0001, 16'h0000);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b1, 16'h00F0, 16'h00F0);

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].gwe, vecs[i].we, vecs[i].rd,
            vecs[i].wdata, vecs[i].rs, vecs[i].rt, vecs[i].chk, vecs[i].exp_rs, vecs[i].exp_rt);
    end

    // Fill every register on consecutive cycles, then read every pair for aliasing.
    for (int k = 0; k < 8; k++)
      apply("fill", 1'b0, 1'b1, 1'b1, 3'(k), 16'h1000 + 16'(k), 3'd0, 3'd0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        apply($sformatf("pair%0d%0d", i, j), 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(j),
              1'b1, 16'h1000 + 16'(i), 16'h1000 + 16'(j));

    // Last of consecutive writes to one register wins.
    apply("dup1", 1'b0, 1'b1, 1'b1, 3'd4, 16'h1111, 3'd0, 3'd0, 1'b0, '0, '0);
    apply("dup2", 1'b0, 1'b1, 1'b1, 3'd4, 16'h2222, 3'd0, 3'd0, 1'b0, '0, '0);
    apply("dup_rd", 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd1, 1'b1, 16'h2222, 16'h1001);

    // Unknown write-side inputs while the write is disabled must not disturb state.
    apply("xgwe0", 1'b0, 1'b0, 1'bx, 3'bxxx, 16'hxxxx, 3'd0, 3'd1, 1'b0, '0, '0);
    apply("xwe0", 1'b0, 1'b1, 1'b0, 3'bxxx, 16'hxxxx, 3'd0, 3'd1, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++)
      apply($sformatf("xhold%0d", k), 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'(k), 3'(7-k),
            1'b1, model[k], model[7-k]);

    // Randomized traffic against the reference array.
    for (int n = 0; n < 400; n++) begin
      logic         r, g, we;
      logic [2:0]   rd, rs, rt;
      logic [W-1:0] wd;
      r  = ($urandom_range(0, 24) == 0);
      g  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) != 0);
      rd = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? rd : 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 4) == 0) ? rs : 3'($urandom_range(0, 7));
      apply("rand", r, g, we, rd, wd, rs, rt, 1'b1,
            model_read(rs, r, g, we, rd, wd), model_read(rt, r, g, we, rd, wd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
